// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter_pkg : shared packet types and CDB arbiter defaults           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cdb_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int TAG_W      = 5;
   localparam int CDB_NUM_FU = 4;
   localparam int CDB_QDEPTH = 2;

   localparam logic [4:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] NPC;
      logic [XLEN-1:0] alu_result;
      logic            take_branch;
      logic [4:0]      dest_reg_idx;
      logic [TAG_W-1:0] Tag;
   } EX_PACKET;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] Tag;
      logic [XLEN-1:0]  Value;
      logic [XLEN-1:0]  NPC;
      logic             take_branch;
      logic [4:0]       dest_reg_idx;
      logic             done;
      logic             halt;
      logic             illegal;
   } CDB_PACKET;

endpackage
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_fifo : per-FU queue of completed EX_PACKETs awaiting the CDB         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int QDEPTH = CDB_QDEPTH
)
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  EX_PACKET                 push_data,
   input  logic                     pop,
   output logic [$clog2(QDEPTH):0]  count,
   output EX_PACKET                 head
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
   localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);

   EX_PACKET         r_mem [QDEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (push) r_tail <= r_tail + c_ptr_one;
         if (pop)  r_head <= r_head + c_ptr_one;
         case ({push, pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; head is only consumed while count is non-zero.
   always_ff @(posedge clock) begin
      if (push && !flush) r_mem[r_tail] <= push_data;
   end

   assign count = r_count;
   assign head  = r_mem[r_head];

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter : round-robin arbitration of FU results onto the CDB        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU = CDB_NUM_FU,
   parameter int QDEPTH = CDB_QDEPTH
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              squash,
   input  logic [NUM_FU-1:0] fu_valid,
   input  EX_PACKET          fu_packet [NUM_FU],
   output logic [NUM_FU-1:0] fu_ready,
   output CDB_PACKET         cdb_packet,
   output logic              wb_regfile_en,
   output logic [4:0]        wb_regfile_idx,
   output logic [XLEN-1:0]   wb_regfile_data
);

   localparam int CNT_W  = $clog2(QDEPTH) + 1;
   localparam int RR_W   = $clog2(NUM_FU);
   localparam int CAND_W = RR_W + 1;

   localparam logic [CNT_W-1:0]  c_depth   = CNT_W'(QDEPTH);
   localparam logic [CAND_W-1:0] c_num_fu  = CAND_W'(NUM_FU);
   localparam logic [RR_W-1:0]   c_last_fu = RR_W'(NUM_FU - 1);
   localparam logic [RR_W-1:0]   c_rr_one  = RR_W'(1);

   logic [CNT_W-1:0]  w_count [NUM_FU];
   EX_PACKET          w_head  [NUM_FU];
   logic [NUM_FU-1:0] w_push;
   logic [NUM_FU-1:0] w_pop;
   logic [NUM_FU-1:0] w_req;
   logic [NUM_FU-1:0] w_unused_valid;
   logic              w_grant;
   logic [RR_W-1:0]   w_grant_idx;
   logic [CAND_W-1:0] w_cand;

   logic [RR_W-1:0]   r_rr_ptr;
   CDB_PACKET         r_cdb;
   logic              r_wb_en;

   generate
      for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
         assign fu_ready[i]       = (w_count[i] < c_depth);
         assign w_req[i]          = (w_count[i] != '0);
         assign w_push[i]         = fu_valid[i] & fu_ready[i] & ~squash;
         assign w_pop[i]          = w_grant && (w_grant_idx == RR_W'(i));
         assign w_unused_valid[i] = w_head[i].valid;

         cdb_fifo #(
            .QDEPTH (QDEPTH)
         ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (squash),
            .push      (w_push[i]),
            .push_data (fu_packet[i]),
            .pop       (w_pop[i]),
            .count     (w_count[i]),
            .head      (w_head[i])
         );
      end
   endgenerate

   // Scan from lowest to highest priority so the rr_ptr-nearest requester wins.
   always_comb begin
      w_grant     = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      for (int k = NUM_FU - 1; k >= 0; k--) begin
         w_cand = {1'b0, r_rr_ptr} + CAND_W'(k);
         if (w_cand >= c_num_fu) w_cand = w_cand - c_num_fu;
         if (w_req[w_cand[RR_W-1:0]]) begin
            w_grant     = 1'b1;
            w_grant_idx = w_cand[RR_W-1:0];
         end
      end
      if (squash) w_grant = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rr_ptr <= '0;
         r_cdb    <= '0;
         r_wb_en  <= 1'b0;
      end else begin
         r_cdb.valid <= w_grant;
         r_wb_en     <= w_grant && (w_head[w_grant_idx].dest_reg_idx != ZERO_REG);
         if (w_grant) begin
            r_rr_ptr           <= (w_grant_idx == c_last_fu) ? '0 : w_grant_idx + c_rr_one;
            r_cdb.Value        <= w_head[w_grant_idx].take_branch ? w_head[w_grant_idx].NPC
                                                                  : w_head[w_grant_idx].alu_result;
            r_cdb.NPC          <= w_head[w_grant_idx].NPC;
            r_cdb.take_branch  <= w_head[w_grant_idx].take_branch;
            r_cdb.dest_reg_idx <= w_head[w_grant_idx].dest_reg_idx;
            r_cdb.Tag          <= w_head[w_grant_idx].Tag;
            r_cdb.done         <= 1'b1;
            r_cdb.halt         <= 1'b0;
            r_cdb.illegal      <= 1'b0;
         end
      end
   end

   assign cdb_packet      = r_cdb;
   assign wb_regfile_en   = r_wb_en;
   assign wb_regfile_idx  = r_cdb.dest_reg_idx;
   assign wb_regfile_data = r_cdb.Value;

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates completing functional-unit results onto the single common data bus (CDB) and regfile write port of the out-of-order core. Each FU pushes finished `EX_PACKET`s into a small private queue. The arbiter grants one queued result per cycle in round-robin order and drives a registered `CDB_PACKET` plus the regfile writeback signals. It sits between the execute stage FUs and the RS/ROB/regfile CDB consumers, and replaces direct single-FU completion.

## Interface
- `NUM_FU`, 4: number of requesting functional units (2..8).
- `QDEPTH`, 2: entries per FU queue (power of two, ≥2).

- `clock`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `reset`  in  1  asynchronous, active-low reset.
- `squash`  in  1  synchronous mispredict flush.
- `fu_valid`  in  NUM_FU  FU i presents a result.
- `fu_packet`  in  EX_PACKET[NUM_FU]  result per FU.
- `fu_ready`  out  NUM_FU  queue i can accept this cycle.
- `cdb_packet`  out  CDB_PACKET  registered broadcast.
- `wb_regfile_en`  out  1  registered regfile write enable.
- `wb_regfile_idx`  out  5  registered write index.
- `wb_regfile_data`  out  XLEN  registered write data.

## Operation
- Push: `fu_valid[i] && fu_ready[i]` writes `fu_packet[i]` into queue i. `fu_packet[i].valid` is ignored.
- `fu_ready[i] = (count[i] < QDEPTH)`. It depends only on registered state, never on `fu_valid` or the current-cycle pop. A full queue that pops this cycle still shows not-ready.
- Arbitration: the requester set is the queues with `count[i] != 0`. `rr_ptr` holds the highest-priority index, searched upward modulo `NUM_FU`. At most one grant per cycle.
- On a grant to i, queue i pops its head and `rr_ptr <= (i+1) mod NUM_FU`. With no grant, `rr_ptr` holds.
- Output register load on a grant:
  - `Value = take_branch ? NPC : alu_result`.
  - `NPC`, `take_branch`, `dest_reg_idx` and `Tag` copied from the packet.
  - `valid = 1`, `done = 1`, `halt = 0`, `illegal = 0`.
- Without a grant, `cdb_packet.valid <= 0` and the other fields hold.
- Regfile outputs:
  - `wb_regfile_en <= grant && dest_reg_idx != ZERO_REG`.
  - idx and data mirror `dest_reg_idx` and `Value`.
  - A zero-dest result still broadcasts with `valid=1` so the ROB can retire it.
- Squash:
  - All counts and pointers clear, and pushes in that cycle are dropped.
  - No grant that cycle, so `cdb_packet.valid` and `wb_regfile_en` are 0 the next cycle.
  - `rr_ptr` holds.
- A push and a pop on the same queue in the same cycle are both legal; count is unchanged.

## Timing
- Reset, asynchronous: all queues empty, `rr_ptr=0`, all `cdb_packet` fields 0, `wb_regfile_en=0`, `wb_regfile_idx=0`, `wb_regfile_data=0`. `fu_ready` is all-ones once reset state is reached.
- Reset mid-operation discards all queued and in-flight results immediately.
- Latency: push at edge t, eligible for arbitration in cycle t+1, on the CDB after edge t+2. The minimum is 2 cycles.
- Throughput: 1 result per cycle total. With all queues non-empty, each FU is granted every `NUM_FU` cycles, so there is no starvation.
- Queue wrap: head and tail pointers are `$clog2(QDEPTH)` bits wide and wrap naturally. `count` is `$clog2(QDEPTH)+1` bits wide.
- Outputs are fully registered. No combinational path runs from `fu_valid` or `fu_packet` to any output.

## Structure
- Shared package (`sys_defs.svh`): `EX_PACKET` and `CDB_PACKET` are already there. Add `CDB_NUM_FU` and `CDB_QDEPTH` defaults and `ZERO_REG` use.
- Sub-module `cdb_fifo`: one per FU via generate. It is a parametric `EX_PACKET` queue with `push`, `pop`, `flush`, `count` and `head` ports.
- The round-robin pick and the output register live in `cdb_arbiter`.

## Test plan
- Reset then idle: `fu_ready=4'b1111`, `cdb_packet.valid=0` for 10 cycles, and all outputs 0.
- Single push on FU2 at cycle 5 (`alu_result=32'h1234`, `dest=7`, `Tag=3`): CDB after the cycle 7 edge shows `valid=1`, `Value=32'h1234`, `Tag=3`, `wb_regfile_en=1`, `idx=7`.
- All 4 FUs push every cycle for 20 cycles: grant order is 0,1,2,3,0,…, `fu_ready` toggles as queues fill, and no packet is lost or duplicated.
- FU1 pushes 3 times back-to-back with QDEPTH=2 while other FUs hold the bus: `fu_ready[1]=0` after 2 pushes and the third is held by FU1 until ready returns.
- Taken branch with `NPC=32'h100`, `dest=0`: `Value=32'h100`, `valid=1`, `wb_regfile_en=0`.
- `squash` with 5 queued entries plus a simultaneous push: the next cycle shows `valid=0`, all counts 0, `fu_ready` all-ones, and `rr_ptr` unchanged.
